// File: rtl/mul_share_arb_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: requester tags,
// the multiply micro-command, default pipe depth / credit count and the
// tag-pipe entry type.
package mul_share_arb_pkg;

    // Requester identifiers carried through the tag pipe
    localparam logic MUL_REQ_A = 1'b0;
    localparam logic MUL_REQ_B = 1'b1;

    // Micro-command for a 32x32 multiply on the shared unit
    localparam logic [8:0] JX2_UCMD_MUL3 = 9'h0B3;

    // Default multiplier depth and per-requester credit / queue depth
    localparam int MUL_LAT_DEF = 2;
    localparam int CRED_DEF    = 3;

    // One slot of the tag pipe: is an op in this stage, and whose is it
    typedef struct packed {
        logic valid;
        logic who;
    } mul_tag_t;

endpackage

// File: rtl/mul_arb_rspq.sv
// Per-requester response FIFO. Holds multiplier results until the owning
// requester takes them. Push and pop on the same edge are both honoured;
// a push into a full queue is dropped (the owner's credits prevent it).
module mul_arb_rspq #(
    parameter int DEPTH = 3,
    parameter int W     = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push_ok;
    logic          pop_ok;

    // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two)
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage, pointers and occupancy count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop_ok) rd_ptr <= ptr_inc(rd_ptr);
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (!push_ok && pop_ok) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/mul_share_arb.sv
// Shares one pipelined 32x32 multiplier between requester A (lane-1 EX)
// and requester B (mul/div sequencer). Grants at most one op per unheld
// cycle, tags it through a MUL_LAT-deep pipe and lands the result in the
// issuing requester's response queue. Credits bound in-flight + queued
// results per requester so the queue can never overflow.
//
// Build option: JX2_MULARB_FIXPRI_EN selects fixed priority (A always
// beats B, B may starve); otherwise contended cycles alternate A/B.
//
// Handshakes: reqXAck is a same-cycle combinational answer to reqXValid;
// an op transfers on an edge where valid && ack. rspXValid/rspXReady
// transfer on an edge where both are high; data holds while not taken.
module mul_share_arb
    import mul_share_arb_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int CRED    = CRED_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        exHold,
    input  logic        reqAValid,
    input  logic [63:0] reqARs,
    input  logic [63:0] reqARt,
    input  logic [8:0]  reqAUCmd,
    input  logic [8:0]  reqAUIxt,
    output logic        reqAAck,
    input  logic        reqBValid,
    input  logic [63:0] reqBRs,
    input  logic [63:0] reqBRt,
    input  logic [8:0]  reqBUCmd,
    input  logic [8:0]  reqBUIxt,
    output logic        reqBAck,
    output logic        rspAValid,
    input  logic        rspAReady,
    output logic [63:0] rspAData,
    output logic        rspBValid,
    input  logic        rspBReady,
    output logic [63:0] rspBData,
    output logic [63:0] mulRs,
    output logic [63:0] mulRt,
    output logic [8:0]  mulUCmd,
    output logic [8:0]  mulUIxt,
    output logic        mulHold,
    input  logic [63:0] mulRn
);

    localparam int CW = $clog2(CRED + 1);

    logic          elig_a, elig_b;
    logic          grant_a, grant_b;
    logic [CW-1:0] cred_a, cred_b;
    mul_tag_t      tag_pipe [MUL_LAT];
    mul_tag_t      tail;
    logic          push_a, push_b;
    logic          pop_a, pop_b;
    logic          full_a, full_b;
    logic          empty_a, empty_b;

`ifndef JX2_MULARB_FIXPRI_EN
    logic rr_ptr;
`endif

    // Eligibility and single-winner grant; nothing is granted under hold or reset
    always_comb begin
        elig_a  = reqAValid && (cred_a != '0) && !exHold && !reset;
        elig_b  = reqBValid && (cred_b != '0) && !exHold && !reset;
        grant_a = 1'b0;
        grant_b = 1'b0;
`ifdef JX2_MULARB_FIXPRI_EN
        grant_a = elig_a;
        grant_b = elig_b && !elig_a;
`else
        if (elig_a && elig_b) begin
            grant_a = (rr_ptr == MUL_REQ_A);
            grant_b = (rr_ptr == MUL_REQ_B);
        end else begin
            grant_a = elig_a;
            grant_b = elig_b;
        end
`endif
    end

    // Operand/command mux to the multiplier; all zero when nothing is granted
    always_comb begin
        mulRs   = '0;
        mulRt   = '0;
        mulUCmd = '0;
        mulUIxt = '0;
        if (grant_a) begin
            mulRs   = reqARs;
            mulRt   = reqARt;
            mulUCmd = reqAUCmd;
            mulUIxt = reqAUIxt;
        end else if (grant_b) begin
            mulRs   = reqBRs;
            mulRt   = reqBRt;
            mulUCmd = reqBUCmd;
            mulUIxt = reqBUIxt;
        end
    end

    assign reqAAck = grant_a;
    assign reqBAck = grant_b;
    assign mulHold = exHold;

`ifndef JX2_MULARB_FIXPRI_EN
    // Round-robin pointer: flips only on a contended grant
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                rr_ptr <= MUL_REQ_A;
        else if (elig_a && elig_b) rr_ptr <= ~rr_ptr;
    end
`endif

    // Tag pipe tracks which requester owns each op inside the multiplier
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MUL_LAT; i++) tag_pipe[i] <= '0;
        end else if (!exHold) begin
            tag_pipe[0].valid <= grant_a || grant_b;
            tag_pipe[0].who   <= grant_b ? MUL_REQ_B : MUL_REQ_A;
            for (int i = 1; i < MUL_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    assign tail   = tag_pipe[MUL_LAT-1];
    assign push_a = !exHold && tail.valid && (tail.who == MUL_REQ_A);
    assign push_b = !exHold && tail.valid && (tail.who == MUL_REQ_B);
    assign pop_a  = rspAValid && rspAReady;
    assign pop_b  = rspBValid && rspBReady;

    // Credits: one per op issued but not yet consumed; same-edge take+return cancels
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cred_a <= CW'(CRED);
            cred_b <= CW'(CRED);
        end else begin
            if (grant_a && !pop_a)
                cred_a <= cred_a - 1'b1;
            else if (!grant_a && pop_a && (cred_a != CW'(CRED)))
                cred_a <= cred_a + 1'b1;
            if (grant_b && !pop_b)
                cred_b <= cred_b - 1'b1;
            else if (!grant_b && pop_b && (cred_b != CW'(CRED)))
                cred_b <= cred_b + 1'b1;
        end
    end

    mul_arb_rspq #(.DEPTH(CRED), .W(64)) u_rspq_a (
        .clk       (clock),
        .rst       (reset),
        .push      (push_a),
        .push_data (mulRn),
        .pop       (pop_a),
        .full      (full_a),
        .empty     (empty_a),
        .head      (rspAData)
    );

    mul_arb_rspq #(.DEPTH(CRED), .W(64)) u_rspq_b (
        .clk       (clock),
        .rst       (reset),
        .push      (push_b),
        .push_data (mulRn),
        .pop       (pop_b),
        .full      (full_b),
        .empty     (empty_b),
        .head      (rspBData)
    );

    assign rspAValid = !empty_a;
    assign rspBValid = !empty_b;

    // Credits guarantee a result always has a free queue slot
    a_no_push_full_a: assert property (@(posedge clock) disable iff (reset) !(push_a && full_a));
    a_no_push_full_b: assert property (@(posedge clock) disable iff (reset) !(push_b && full_b));

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed bench for mul_share_arb with a behavioural 2-stage multiplier.
// Honours JX2_MULARB_FIXPRI_EN for the contention scenario.
module tb_mul_share_arb;
    import mul_share_arb_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        exHold;
    logic        reqAValid, reqBValid;
    logic [63:0] reqARs, reqARt, reqBRs, reqBRt;
    logic [8:0]  reqAUCmd, reqAUIxt, reqBUCmd, reqBUIxt;
    logic        reqAAck, reqBAck;
    logic        rspAValid, rspBValid, rspAReady, rspBReady;
    logic [63:0] rspAData, rspBData;
    logic [63:0] mulRs, mulRt, mulRn;
    logic [8:0]  mulUCmd, mulUIxt;
    logic        mulHold;

    int checks = 0;
    int errors = 0;

    logic [63:0] got_a [$];
    logic [63:0] got_b [$];
    logic [63:0] m1 = '0;
    logic [63:0] m2 = '0;

    // Operand tables for the contention scenario
    logic [63:0] a_rs [4] = '{64'd2, 64'd4, 64'd6, 64'd8};
    logic [63:0] a_rt [4] = '{64'd3, 64'd5, 64'd7, 64'd9};
    logic [63:0] b_op [4] = '{64'd10, 64'd11, 64'd12, 64'd13};

    mul_share_arb dut (
        .clock(clock), .reset(reset), .exHold(exHold),
        .reqAValid(reqAValid), .reqARs(reqARs), .reqARt(reqARt),
        .reqAUCmd(reqAUCmd), .reqAUIxt(reqAUIxt), .reqAAck(reqAAck),
        .reqBValid(reqBValid), .reqBRs(reqBRs), .reqBRt(reqBRt),
        .reqBUCmd(reqBUCmd), .reqBUIxt(reqBUIxt), .reqBAck(reqBAck),
        .rspAValid(rspAValid), .rspAReady(rspAReady), .rspAData(rspAData),
        .rspBValid(rspBValid), .rspBReady(rspBReady), .rspBData(rspBData),
        .mulRs(mulRs), .mulRt(mulRt), .mulUCmd(mulUCmd), .mulUIxt(mulUIxt),
        .mulHold(mulHold), .mulRn(mulRn)
    );

    // Clock
    always #5 clock = ~clock;

    // Two-stage multiplier model, frozen by mulHold, never reset
    always @(posedge clock) begin
        if (!mulHold) begin
            m1 <= 64'(mulRs[31:0]) * 64'(mulRt[31:0]);
            m2 <= m1;
        end
    end
    assign mulRn = m2;

    // Record every consumed response
    always @(negedge clock) begin
        if (!reset && rspAValid && rspAReady) got_a.push_back(rspAData);
        if (!reset && rspBValid && rspBReady) got_b.push_back(rspBData);
    end

    task automatic next_cycle;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs;
        exHold = 0; reqAValid = 0; reqBValid = 0;
        reqARs = '0; reqARt = '0; reqBRs = '0; reqBRt = '0;
        reqAUCmd = JX2_UCMD_MUL3; reqAUIxt = 9'h001;
        reqBUCmd = JX2_UCMD_MUL3; reqBUIxt = 9'h002;
        rspAReady = 0; rspBReady = 0;
    endtask

    // Leaves time at posedge+1 with reset released
    task automatic do_reset;
        clear_inputs();
        reset = 1;
        next_cycle();
        next_cycle();
        reset = 0;
        got_a.delete();
        got_b.delete();
    endtask

    task automatic test_reset;
        clear_inputs();
        reset = 1;
        reqAValid = 1; reqBValid = 1; reqARs = 64'd5; reqARt = 64'd5;
        @(negedge clock);
        checks++;
        if ({reqAAck, reqBAck} !== 2'b00) begin
            errors++; $display("FAIL reset_ack: got %b expected 00", {reqAAck, reqBAck});
        end
        checks++;
        if ({rspAValid, rspBValid} !== 2'b00) begin
            errors++; $display("FAIL reset_rsp_valid: got %b expected 00", {rspAValid, rspBValid});
        end
        checks++;
        if (mulUCmd !== 9'd0 || mulRs !== 64'd0) begin
            errors++; $display("FAIL reset_mul_out: got ucmd=%0h rs=%0d expected 0 0", mulUCmd, mulRs);
        end
        exHold = 1;
        #1;
        checks++;
        if (mulHold !== 1'b1) begin
            errors++; $display("FAIL reset_mulhold: got %b expected 1", mulHold);
        end
        do_reset();
    endtask

    task automatic test_a_only;
        do_reset();
        reqAValid = 1; reqARs = 64'd7; reqARt = 64'd6; reqAUIxt = 9'h005;
        @(negedge clock);
        checks++;
        if (reqAAck !== 1'b1 || reqBAck !== 1'b0) begin
            errors++; $display("FAIL a_only_ack: got a=%b b=%b expected a=1 b=0", reqAAck, reqBAck);
        end
        checks++;
        if (mulRs !== 64'd7 || mulRt !== 64'd6 || mulUCmd !== JX2_UCMD_MUL3 || mulUIxt !== 9'h005) begin
            errors++; $display("FAIL a_only_mul_ops: got rs=%0d rt=%0d ucmd=%0h uixt=%0h expected 7 6 %0h 5",
                               mulRs, mulRt, mulUCmd, mulUIxt, JX2_UCMD_MUL3);
        end
        next_cycle();
        reqAValid = 0; reqARs = '0; reqARt = '0;
        @(negedge clock);
        checks++;
        if (mulUCmd !== 9'd0 || rspAValid !== 1'b0) begin
            errors++; $display("FAIL a_only_idle: got ucmd=%0h rspv=%b expected 0 0", mulUCmd, rspAValid);
        end
        next_cycle();
        @(negedge clock);
        checks++;
        if (rspAValid !== 1'b0) begin
            errors++; $display("FAIL a_only_early: got rspAValid=%b expected 0", rspAValid);
        end
        next_cycle();
        @(negedge clock);
        checks++;
        if (rspAValid !== 1'b1 || rspAData !== 64'd42 || rspBValid !== 1'b0) begin
            errors++; $display("FAIL a_only_result: got v=%b d=%0d bv=%b expected 1 42 0",
                               rspAValid, rspAData, rspBValid);
        end
        next_cycle();
        rspAReady = 1;
        @(negedge clock);
        checks++;
        if (rspAValid !== 1'b1 || rspAData !== 64'd42) begin
            errors++; $display("FAIL a_only_hold_result: got v=%b d=%0d expected 1 42", rspAValid, rspAData);
        end
        next_cycle();
        rspAReady = 0;
        @(negedge clock);
        checks++;
        if (rspAValid !== 1'b0) begin
            errors++; $display("FAIL a_only_popped: got rspAValid=%b expected 0", rspAValid);
        end
    endtask

    task automatic test_contention;
        int ia;
        int ib;
        int n;
        logic [1:0] exp_ack [4];
        logic [63:0] exp_a [$];
        logic [63:0] exp_b [$];
`ifdef JX2_MULARB_FIXPRI_EN
        n = 3;
        exp_ack = '{2'b10, 2'b10, 2'b10, 2'b10};
        exp_a = '{64'd6, 64'd20, 64'd42};
        exp_b = {};
`else
        n = 4;
        exp_ack = '{2'b10, 2'b01, 2'b10, 2'b01};
        exp_a = '{64'd6, 64'd20};
        exp_b = '{64'd100, 64'd121};
`endif
        do_reset();
        rspAReady = 1; rspBReady = 1;
        ia = 0; ib = 0;
        for (int c = 0; c < n; c++) begin
            reqAValid = 1; reqARs = a_rs[ia]; reqARt = a_rt[ia];
            reqBValid = 1; reqBRs = b_op[ib]; reqBRt = b_op[ib];
            @(negedge clock);
            checks++;
            if ({reqAAck, reqBAck} !== exp_ack[c]) begin
                errors++; $display("FAIL contention_grant_c%0d: got ab=%b expected %b", c, {reqAAck, reqBAck}, exp_ack[c]);
            end
            if (reqAAck === 1'b1 && ia < 3) ia++;
            if (reqBAck === 1'b1 && ib < 3) ib++;
            next_cycle();
        end
        reqAValid = 0; reqBValid = 0;
        repeat (8) next_cycle();
        checks++;
        if (got_a.size() != exp_a.size() || got_b.size() != exp_b.size()) begin
            errors++; $display("FAIL contention_counts: got a=%0d b=%0d expected a=%0d b=%0d",
                               got_a.size(), got_b.size(), exp_a.size(), exp_b.size());
        end
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            checks++;
            if (got_a[i] !== exp_a[i]) begin
                errors++; $display("FAIL contention_a_data%0d: got %0d expected %0d", i, got_a[i], exp_a[i]);
            end
        end
        for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
            checks++;
            if (got_b[i] !== exp_b[i]) begin
                errors++; $display("FAIL contention_b_data%0d: got %0d expected %0d", i, got_b[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_credits;
        logic [63:0] ops [5] = '{64'd3, 64'd4, 64'd5, 64'd6, 64'd0};
        logic exp_ack [10] = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 0};
        logic [63:0] exp_a [4] = '{64'd9, 64'd16, 64'd25, 64'd36};
        int idx;
        do_reset();
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            reqAValid = (idx < 4);
            reqARs = ops[idx]; reqARt = ops[idx];
            rspAReady = (c >= 7);
            @(negedge clock);
            checks++;
            if (reqAAck !== exp_ack[c]) begin
                errors++; $display("FAIL credits_ack_c%0d: got %b expected %b", c, reqAAck, exp_ack[c]);
            end
            if (c == 6) begin
                checks++;
                if (rspAValid !== 1'b1 || rspAData !== 64'd9) begin
                    errors++; $display("FAIL credits_head: got v=%b d=%0d expected 1 9", rspAValid, rspAData);
                end
            end
            if (reqAAck === 1'b1) idx++;
            next_cycle();
        end
        reqAValid = 0;
        repeat (6) next_cycle();
        checks++;
        if (got_a.size() != 4) begin
            errors++; $display("FAIL credits_count: got %0d expected 4", got_a.size());
        end
        for (int i = 0; i < 4 && i < got_a.size(); i++) begin
            checks++;
            if (got_a[i] !== exp_a[i]) begin
                errors++; $display("FAIL credits_order%0d: got %0d expected %0d", i, got_a[i], exp_a[i]);
            end
        end
        rspAReady = 0;
    endtask

    task automatic test_hold;
        do_reset();
        rspAReady = 1; rspBReady = 1;
        reqAValid = 1; reqARs = 64'd8; reqARt = 64'd9;
        @(negedge clock);
        checks++;
        if (reqAAck !== 1'b1) begin
            errors++; $display("FAIL hold_issue_a: got %b expected 1", reqAAck);
        end
        next_cycle();
        reqAValid = 0; reqBValid = 1; reqBRs = 64'd7; reqBRt = 64'd7;
        @(negedge clock);
        checks++;
        if (reqBAck !== 1'b1) begin
            errors++; $display("FAIL hold_issue_b: got %b expected 1", reqBAck);
        end
        next_cycle();
        exHold = 1; reqAValid = 1; reqARs = 64'd1; reqARt = 64'd1; reqBRs = 64'd2; reqBRt = 64'd2;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            checks++;
            if ({reqAAck, reqBAck, rspAValid, rspBValid, mulHold} !== 5'b00001 || mulUCmd !== 9'd0) begin
                errors++; $display("FAIL hold_frozen_c%0d: got ackA=%b ackB=%b rspA=%b rspB=%b hold=%b ucmd=%0h expected 0 0 0 0 1 0",
                                   c, reqAAck, reqBAck, rspAValid, rspBValid, mulHold, mulUCmd);
            end
            next_cycle();
        end
        exHold = 0; reqAValid = 0; reqBValid = 0;
        @(negedge clock);
        checks++;
        if (rspAValid !== 1'b0) begin
            errors++; $display("FAIL hold_release_early: got %b expected 0", rspAValid);
        end
        next_cycle();
        @(negedge clock);
        checks++;
        if (rspAValid !== 1'b1 || rspAData !== 64'd72 || rspBValid !== 1'b0) begin
            errors++; $display("FAIL hold_result_a: got v=%b d=%0d bv=%b expected 1 72 0", rspAValid, rspAData, rspBValid);
        end
        next_cycle();
        @(negedge clock);
        checks++;
        if (rspBValid !== 1'b1 || rspBData !== 64'd49 || rspAValid !== 1'b0) begin
            errors++; $display("FAIL hold_result_b: got v=%b d=%0d av=%b expected 1 49 0", rspBValid, rspBData, rspAValid);
        end
        next_cycle();
        rspAReady = 0; rspBReady = 0;
    endtask

    task automatic test_reset_mid;
        logic [63:0] ops [3] = '{64'd2, 64'd3, 64'd5};
        logic exp_ack [4] = '{1, 1, 1, 0};
        do_reset();
        for (int c = 0; c < 3; c++) begin
            reqAValid = 1; reqARs = ops[c]; reqARt = ops[c];
            next_cycle();
        end
        reqAValid = 0;
        @(negedge clock);
        checks++;
        if (rspAValid !== 1'b1 || rspAData !== 64'd4) begin
            errors++; $display("FAIL rstmid_pre: got v=%b d=%0d expected 1 4", rspAValid, rspAData);
        end
        #2;
        reset = 1;
        #1;
        checks++;
        if ({rspAValid, rspBValid} !== 2'b00) begin
            errors++; $display("FAIL rstmid_async: got %b expected 00", {rspAValid, rspBValid});
        end
        next_cycle();
        next_cycle();
        reset = 0;
        rspAReady = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            checks++;
            if (rspAValid !== 1'b0) begin
                errors++; $display("FAIL rstmid_stale_c%0d: got v=%b d=%0d expected 0", c, rspAValid, rspAData);
            end
            next_cycle();
        end
        rspAReady = 0;
        for (int c = 0; c < 4; c++) begin
            reqAValid = 1; reqARs = 64'd6; reqARt = 64'd7;
            @(negedge clock);
            checks++;
            if (reqAAck !== exp_ack[c]) begin
                errors++; $display("FAIL rstmid_credit_c%0d: got %b expected %b", c, reqAAck, exp_ack[c]);
            end
            next_cycle();
        end
        reqAValid = 0;
        @(negedge clock);
        checks++;
        if (rspAValid !== 1'b1 || rspAData !== 64'd42) begin
            errors++; $display("FAIL rstmid_new_result: got v=%b d=%0d expected 1 42", rspAValid, rspAData);
        end
        do_reset();
    endtask

    task automatic test_same_edge;
        logic [63:0] exp_a [4] = '{64'd2, 64'd9, 64'd16, 64'd25};
        do_reset();
        reqAValid = 1; reqARs = 64'd1; reqARt = 64'd2;
        next_cycle();
        reqARs = 64'd3; reqARt = 64'd3;
        next_cycle();
        reqAValid = 0;
        next_cycle();
        reqAValid = 1; reqARs = 64'd4; reqARt = 64'd4; rspAReady = 1;
        @(negedge clock);
        checks++;
        if (reqAAck !== 1'b1 || rspAValid !== 1'b1 || rspAData !== 64'd2) begin
            errors++; $display("FAIL same_edge_c3: got ack=%b v=%b d=%0d expected 1 1 2", reqAAck, rspAValid, rspAData);
        end
        next_cycle();
        rspAReady = 0; reqARs = 64'd5; reqARt = 64'd5;
        @(negedge clock);
        checks++;
        if (reqAAck !== 1'b1) begin
            errors++; $display("FAIL same_edge_credit_kept: got %b expected 1", reqAAck);
        end
        next_cycle();
        reqARs = 64'd7; reqARt = 64'd7;
        @(negedge clock);
        checks++;
        if (reqAAck !== 1'b0) begin
            errors++; $display("FAIL same_edge_credit_out: got %b expected 0", reqAAck);
        end
        next_cycle();
        reqAValid = 0; rspAReady = 1;
        repeat (8) next_cycle();
        checks++;
        if (got_a.size() != 4 || rspAValid !== 1'b0) begin
            errors++; $display("FAIL same_edge_count: got n=%0d v=%b expected 4 0", got_a.size(), rspAValid);
        end
        for (int i = 0; i < 4 && i < got_a.size(); i++) begin
            checks++;
            if (got_a[i] !== exp_a[i]) begin
                errors++; $display("FAIL same_edge_order%0d: got %0d expected %0d", i, got_a[i], exp_a[i]);
            end
        end
        rspAReady = 0;
    endtask

    // Upper bound on run time
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_a_only();
        test_contention();
        test_credits();
        test_hold();
        test_reset_mid();
        test_same_edge();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
